// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS fetch stage and the multi-cycle datapath control.
// Opcode constants, fetch FSM states and the branch-offset helper.
package mips_fetch_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_HALT  = 6'd63;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        HOLD,
        NEXT,
        HALT
    } fetch_state_t;

    // Sign-extended word offset of a beq, already scaled to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_imem.sv
// Instruction store: synchronous write port for program loading, combinational read.
// Contents survive reset so a loaded program can be re-run.
module fetch_imem #(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mips_fetch_unit.sv
// Fetch stage: PC register, instruction-period FSM and next-PC selection.
// One instruction word per CYCLES_PER_INSTR clocks; state is exported for observation.
module mips_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int IMEM_DEPTH       = 128,
    parameter int CYCLES_PER_INSTR = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         run,
    input  logic         load_en,
    input  logic [6:0]   load_addr,
    input  logic [31:0]  load_data,
    input  logic         branch_zero,
    output logic [31:0]  instrword,
    output logic         newinstr,
    output logic [31:0]  pc,
    output logic         halted,
    output fetch_state_t state
);

    // HOLD lasts hold_cnt+1 cycles, so FETCH + HOLD + NEXT totals CYCLES_PER_INSTR.
    localparam logic [3:0] HOLD_INIT = 4'(CYCLES_PER_INSTR - 3);

    logic [3:0]  hold_cnt;
    logic [5:0]  opcode;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        out_of_range;
    logic        imem_we;
    logic [6:0]  rd_addr;
    logic [31:0] rd_data;

    assign opcode = instrword[31:26];

    always_comb begin
        pc_plus4 = pc + 32'd4;
        next_pc  = pc_plus4;
        case (opcode)
            OP_BEQ: begin
                if (branch_zero) begin
                    next_pc = pc_plus4 + branch_offset(instrword[15:0]);
                end
            end
            OP_J:    next_pc = {pc_plus4[31:28], instrword[25:0], 2'b00};
            default: next_pc = pc_plus4;
        endcase
    end

    assign out_of_range = |next_pc[31:9];

    // In NEXT the following word is fetched on the same edge the PC advances.
    assign rd_addr = (state == NEXT) ? next_pc[8:2] : pc[8:2];
    assign imem_we = load_en && ((state == IDLE) || (state == HALT));

    fetch_imem #(
        .DEPTH (IMEM_DEPTH),
        .AW    (7)
    ) u_imem (
        .clock   (clock),
        .wr_en   (imem_we),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= 32'd0;
            instrword <= 32'd0;
            newinstr  <= 1'b0;
            halted    <= 1'b0;
            hold_cnt  <= 4'd0;
        end else begin
            newinstr <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) begin
                        state     <= FETCH;
                        instrword <= rd_data;
                        newinstr  <= 1'b1;
                    end
                end
                FETCH: begin
                    state    <= HOLD;
                    hold_cnt <= HOLD_INIT;
                end
                HOLD: begin
                    if (hold_cnt == 4'd0) begin
                        state <= NEXT;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                NEXT: begin
                    if (opcode == OP_HALT) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        pc <= next_pc;
                        if (out_of_range) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else if (run) begin
                            state     <= FETCH;
                            instrword <= rd_data;
                            newinstr  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: sequencing, beq/j next-PC, halt, reset and load gating.
module tb_mips_fetch_unit;
    import mips_fetch_pkg::*;

    localparam logic [31:0] W_ADD   = 32'h0022_1820;
    localparam logic [31:0] W_SUB   = 32'h0022_1822;
    localparam logic [31:0] W_OR    = 32'h0022_1825;
    localparam logic [31:0] W_HALT  = 32'hFC00_0000;
    localparam logic [31:0] W_BEQ2  = 32'h1000_0002;
    localparam logic [31:0] W_BEQM1 = 32'h1000_FFFF;
    localparam logic [31:0] W_J2    = 32'h0800_0002;
    localparam logic [31:0] W_J3    = 32'h0800_0003;
    localparam logic [31:0] W_J200  = 32'h0800_00C8;
    localparam logic [31:0] W_DEAD  = 32'hDEAD_BEEF;

    logic         clock;
    logic         reset;
    logic         run;
    logic         load_en;
    logic [6:0]   load_addr;
    logic [31:0]  load_data;
    logic         branch_zero;
    logic [31:0]  instrword;
    logic         newinstr;
    logic [31:0]  pc;
    logic         halted;
    fetch_state_t state;

    int n_checks = 0;
    int n_pass   = 0;
    int pulses;

    mips_fetch_unit #(
        .IMEM_DEPTH       (128),
        .CYCLES_PER_INSTR (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .branch_zero (branch_zero),
        .instrword   (instrword),
        .newinstr    (newinstr),
        .pc          (pc),
        .halted      (halted),
        .state       (state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance n clock edges and land 1ns after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic load(input logic [6:0] addr, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        tick(1);
        load_en   = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        run         = 1'b0;
        load_en     = 1'b0;
        load_addr   = 7'd0;
        load_data   = 32'd0;
        branch_zero = 1'b0;
        tick(2);
        chk("rst_pc", pc, 32'd0);
        chk("rst_instr", instrword, 32'd0);
        chk("rst_new", 32'(newinstr), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_state", 32'(state), 32'(IDLE));
        reset = 1'b0;
        tick(1);

        // Straight-line program; branch_zero held high must not affect non-beq words.
        load(7'd0, W_ADD);
        load(7'd1, W_SUB);
        load(7'd2, W_OR);
        load(7'd3, W_HALT);
        branch_zero = 1'b1;
        run = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            tick(1);
            chk($sformatf("seq_new_c%0d", c), 32'(newinstr),
                ((c == 1) || (c == 5) || (c == 9) || (c == 13)) ? 32'd1 : 32'd0);
            if (c == 1)  begin chk("seq_i0", instrword, W_ADD);  chk("seq_pc0", pc, 32'd0);  end
            if (c == 5)  begin chk("seq_i1", instrword, W_SUB);  chk("seq_pc1", pc, 32'd4);  end
            if (c == 9)  begin chk("seq_i2", instrword, W_OR);   chk("seq_pc2", pc, 32'd8);  end
            if (c == 13) begin chk("seq_i3", instrword, W_HALT); chk("seq_pc3", pc, 32'd12); end
            if (c == 16) chk("seq_not_yet_halted", 32'(halted), 32'd0);
        end
        chk("seq_halted", 32'(halted), 32'd1);
        chk("seq_halt_state", 32'(state), 32'(HALT));
        tick(3);
        chk("seq_halt_pc", pc, 32'd12);
        chk("seq_halt_sticky", 32'(halted), 32'd1);
        chk("seq_halt_new", 32'(newinstr), 32'd0);

        // beq +2 taken from pc 0.
        run = 1'b0;
        pulse_reset();
        chk("rst2_halted", 32'(halted), 32'd0);
        tick(1);
        load(7'd0, W_BEQ2);
        load(7'd1, W_J3);
        branch_zero = 1'b1;
        run = 1'b1;
        tick(1);
        chk("beq_t_instr", instrword, W_BEQ2);
        tick(4);
        chk("beq_t_pc", pc, 32'd12);
        chk("beq_t_new", 32'(newinstr), 32'd1);
        chk("beq_t_instr2", instrword, W_HALT);
        tick(4);
        chk("beq_t_halted", 32'(halted), 32'd1);

        // beq not taken, then j target 3 from pc 4.
        run = 1'b0;
        pulse_reset();
        branch_zero = 1'b0;
        run = 1'b1;
        tick(5);
        chk("beq_nt_pc", pc, 32'd4);
        chk("beq_nt_instr", instrword, W_J3);
        branch_zero = 1'b1;
        tick(4);
        chk("j3_pc", pc, 32'd12);
        chk("j3_instr", instrword, W_HALT);

        // Negative beq offset loops on itself.
        run = 1'b0;
        pulse_reset();
        branch_zero = 1'b0;
        tick(1);
        load(7'd0, W_J2);
        load(7'd2, W_BEQM1);
        branch_zero = 1'b1;
        run = 1'b1;
        tick(5);
        chk("j2_pc", pc, 32'd8);
        chk("j2_instr", instrword, W_BEQM1);
        tick(4);
        chk("beqm1_pc", pc, 32'd8);
        chk("beqm1_refetch_new", 32'(newinstr), 32'd1);
        chk("beqm1_instr", instrword, W_BEQM1);
        branch_zero = 1'b0;
        tick(4);
        chk("beqm1_nt_pc", pc, 32'd12);

        // Jump out of range halts with the new pc.
        run = 1'b0;
        pulse_reset();
        tick(1);
        load(7'd0, W_J200);
        run = 1'b1;
        tick(5);
        chk("oor_state", 32'(state), 32'(HALT));
        chk("oor_halted", 32'(halted), 32'd1);
        chk("oor_pc", pc, 32'd800);
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            tick(1);
            if (newinstr) pulses++;
        end
        chk("oor_no_pulses", 32'(pulses), 32'd0);
        run = 1'b0;
        load(7'd0, W_HALT);
        chk("halt_load_sticky", 32'(halted), 32'd1);
        pulse_reset();
        run = 1'b1;
        tick(1);
        chk("halt_load_written", instrword, W_HALT);

        // Asynchronous reset during FETCH and during HOLD.
        run = 1'b0;
        pulse_reset();
        tick(1);
        load(7'd0, W_ADD);
        load(7'd1, W_SUB);
        load(7'd2, W_OR);
        load(7'd3, W_HALT);
        run = 1'b1;
        tick(1);
        reset = 1'b1;
        #1;
        chk("arst_fetch_new", 32'(newinstr), 32'd0);
        chk("arst_fetch_instr", instrword, 32'd0);
        reset = 1'b0;
        tick(6);
        chk("pre_arst_hold_pc", pc, 32'd4);
        chk("pre_arst_hold_state", 32'(state), 32'(HOLD));
        reset = 1'b1;
        #1;
        chk("arst_hold_pc", pc, 32'd0);
        chk("arst_hold_instr", instrword, 32'd0);
        chk("arst_hold_state", 32'(state), 32'(IDLE));
        reset = 1'b0;
        tick(1);
        chk("rerun_instr", instrword, W_ADD);
        chk("rerun_pc", pc, 32'd0);

        // run dropped in HOLD; load attempted in HOLD is ignored.
        tick(1);
        run       = 1'b0;
        load_en   = 1'b1;
        load_addr = 7'd1;
        load_data = W_DEAD;
        tick(2);
        load_en = 1'b0;
        chk("drop_next_state", 32'(state), 32'(NEXT));
        tick(1);
        chk("drop_idle_state", 32'(state), 32'(IDLE));
        chk("drop_idle_pc", pc, 32'd4);
        chk("drop_idle_new", 32'(newinstr), 32'd0);
        run = 1'b1;
        tick(1);
        chk("hold_load_ignored", instrword, W_SUB);
        run = 1'b0;
        tick(4);
        chk("idle2_pc", pc, 32'd8);
        load(7'd2, W_DEAD);
        run = 1'b1;
        tick(1);
        chk("idle_load_written", instrword, W_DEAD);
        run = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
